// File: rtl/somador_fa.sv
// rtl/somador_fa.sv - ripple-carry full adder with registered sum, carry and overflow
//
// Purpose:
//   WIDTH identical full-adder cells chained by a ripple carry (no lookahead).
//   s/co are purely combinational. s_q/co_q/ovf_q are a registered copy of the
//   result for downstream clocked logic.
//
// Ports:
//   clk    in   1      rising-edge clock for the output registers
//   rst_n  in   1      asynchronous active-low reset of the output registers
//   en     in   1      register load enable (combinational path ignores it)
//   i0     in   WIDTH  operand A
//   i1     in   WIDTH  operand B
//   ci     in   1      carry in
//   s      out  WIDTH  combinational sum, (i0+i1+ci) mod 2^WIDTH
//   co     out  1      combinational carry out
//   s_q    out  WIDTH  registered sum
//   co_q   out  1      registered carry out
//   ovf_q  out  1      registered two's-complement overflow

module somador_fa #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic [WIDTH-1:0] s_q,
   output logic             co_q,
   output logic             ovf_q
);

   // c[k] is the carry into cell k; c[WIDTH] is the final carry out.
   logic [WIDTH:0] c;
   logic           ovf;

   assign c[0] = ci;

   genvar k;
   generate
      for (k = 0; k < WIDTH; k++) begin : g_cell
         assign s[k]   = i0[k] ^ i1[k] ^ c[k];
         assign c[k+1] = (i0[k] & i1[k]) | (i0[k] & c[k]) | (i1[k] & c[k]);
      end
   endgenerate

   assign co = c[WIDTH];

   // Signed overflow: carry into the sign cell differs from carry out of it.
   // For WIDTH=1 the carry into the sign cell is ci itself.
   assign ovf = c[WIDTH] ^ c[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= '0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (en) begin
         s_q   <= s;
         co_q  <= co;
         ovf_q <= ovf;
      end
   end

endmodule

// File: tb/tb_somador_fa.sv
// tb/tb_somador_fa.sv - scoreboard bench for somador_fa at WIDTH=1 and WIDTH=4

module tb_somador_fa;

   logic       clk;
   logic       rst_n;
   logic       en;

   logic [0:0] a1, b1;
   logic       c1;
   logic [0:0] s1, sq1;
   logic       co1, coq1, ovfq1;

   logic [3:0] a4, b4;
   logic       c4;
   logic [3:0] s4, sq4;
   logic       co4, coq4, ovfq4;

   somador_fa #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .i0    (a1),
      .i1    (b1),
      .ci    (c1),
      .s     (s1),
      .co    (co1),
      .s_q   (sq1),
      .co_q  (coq1),
      .ovf_q (ovfq1)
   );

   somador_fa #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .i0    (a4),
      .i1    (b4),
      .ci    (c4),
      .s     (s4),
      .co    (co4),
      .s_q   (sq4),
      .co_q  (coq4),
      .ovf_q (ovfq4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      int         unit;
      bit         is_reg;
      logic [3:0] sv;
      logic       cov;
      logic       ovfv;
      string      name;
   } item_t;

   item_t q[$];
   item_t it;
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void cmp(string name, logic [3:0] act, logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: outputs are sampled on the falling edge, away from the loading edge.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         it = q.pop_front();
         if (it.due < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: stale expectation due %0d seen at %0d", it.name, it.due, cyc);
         end else if (it.unit == 1) begin
            if (it.is_reg) begin
               cmp({it.name, ".s_q"},   {3'b0, sq1},   it.sv);
               cmp({it.name, ".co_q"},  {3'b0, coq1},  {3'b0, it.cov});
               cmp({it.name, ".ovf_q"}, {3'b0, ovfq1}, {3'b0, it.ovfv});
            end else begin
               cmp({it.name, ".s"},  {3'b0, s1},  it.sv);
               cmp({it.name, ".co"}, {3'b0, co1}, {3'b0, it.cov});
            end
         end else begin
            if (it.is_reg) begin
               cmp({it.name, ".s_q"},   sq4,           it.sv);
               cmp({it.name, ".co_q"},  {3'b0, coq4},  {3'b0, it.cov});
               cmp({it.name, ".ovf_q"}, {3'b0, ovfq4}, {3'b0, it.ovfv});
            end else begin
               cmp({it.name, ".s"},  s4,           it.sv);
               cmp({it.name, ".co"}, {3'b0, co4},  {3'b0, it.cov});
            end
         end
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_comb(int unit, logic [3:0] sv, logic cov, string name);
      item_t e;
      e.due = cyc; e.unit = unit; e.is_reg = 1'b0;
      e.sv = sv; e.cov = cov; e.ovfv = 1'b0; e.name = name;
      q.push_back(e);
   endtask

   // delay=0: registers checked this cycle; delay=1: after the next rising edge.
   task automatic exp_reg(int unit, int delay, logic [3:0] sv, logic cov, logic ovfv, string name);
      item_t e;
      e.due = cyc + delay; e.unit = unit; e.is_reg = 1'b1;
      e.sv = sv; e.cov = cov; e.ovfv = ovfv; e.name = name;
      q.push_back(e);
   endtask

   task automatic drive1(logic a, logic b, logic c);
      a1 = a; b1 = b; c1 = c;
   endtask

   // Hand-written 1-bit truth table, indexed by {i0,i1,ci}, entries {s,co}.
   logic [1:0] tt [8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
      rst_n = 1'b0;
      en    = 1'b0;
      a1 = '0; b1 = '0; c1 = 1'b0;
      a4 = '0; b4 = '0; c4 = 1'b0;
      go(); go();

      // Reset state; combinational path live during reset
      drive1(1'b1, 1'b0, 1'b1);
      exp_comb(1, 4'h0, 1'b1, "rst_comb");
      exp_reg(1, 0, 4'h0, 1'b0, 1'b0, "rst_reg1");
      exp_reg(4, 0, 4'h0, 1'b0, 1'b0, "rst_reg4");

      go();
      rst_n = 1'b1;

      // Exhaustive 1-bit truth table at 10 ns spacing, en=0
      for (int i = 0; i < 8; i++) begin
         go();
         {a1, b1, c1} = i[2:0];
         exp_comb(1, {3'b0, tt[i][1]}, tt[i][0], $sformatf("tt%0d", i));
      end
      exp_reg(1, 0, 4'h0, 1'b0, 1'b0, "hold_after_rst");

      // Registered path
      go(); en = 1'b1;
      drive1(1'b1, 1'b1, 1'b1);
      exp_comb(1, 4'h1, 1'b1, "r111");
      exp_reg(1, 1, 4'h1, 1'b1, 1'b0, "rq111");
      go();
      drive1(1'b0, 1'b1, 1'b0);
      exp_comb(1, 4'h1, 1'b0, "r010");
      exp_reg(1, 1, 4'h1, 1'b0, 1'b0, "rq010");
      go();
      drive1(1'b0, 1'b0, 1'b1);
      exp_comb(1, 4'h1, 1'b0, "r001");
      exp_reg(1, 1, 4'h1, 1'b0, 1'b1, "rq001");
      go();
      drive1(1'b1, 1'b1, 1'b1);
      exp_reg(1, 1, 4'h1, 1'b1, 1'b0, "preload");
      go();

      // Async reset between edges
      go();
      rst_n = 1'b0;
      exp_reg(1, 0, 4'h0, 1'b0, 1'b0, "async_clr1");
      exp_reg(4, 0, 4'h0, 1'b0, 1'b0, "async_clr4");
      drive1(1'b0, 1'b1, 1'b0);
      exp_comb(1, 4'h1, 1'b0, "rst_follow");
      go();
      drive1(1'b1, 1'b1, 1'b1);
      exp_comb(1, 4'h1, 1'b1, "rst_follow2");
      exp_reg(1, 0, 4'h0, 1'b0, 1'b0, "rst_held1");
      go();
      drive1(1'b1, 1'b0, 1'b0);
      exp_comb(1, 4'h1, 1'b0, "rst_follow3");
      exp_reg(1, 0, 4'h0, 1'b0, 1'b0, "rst_held2");

      // Release, load, then hold with en=0
      go();
      rst_n = 1'b1;
      drive1(1'b1, 1'b0, 1'b1);
      exp_comb(1, 4'h0, 1'b1, "h101");
      exp_reg(1, 1, 4'h0, 1'b1, 1'b0, "first_load");
      go();
      en = 1'b0;
      drive1(1'b1, 1'b1, 1'b0);
      exp_comb(1, 4'h0, 1'b1, "h110");
      exp_reg(1, 1, 4'h0, 1'b1, 1'b0, "hold1");
      go();
      drive1(1'b0, 1'b0, 1'b0);
      exp_comb(1, 4'h0, 1'b0, "h000");
      exp_reg(1, 1, 4'h0, 1'b1, 1'b0, "hold2");
      go();
      drive1(1'b1, 1'b1, 1'b1);
      exp_comb(1, 4'h1, 1'b1, "h111");
      exp_reg(1, 1, 4'h0, 1'b1, 1'b0, "hold3");
      go();

      // WIDTH=4 wrap and overflow
      en = 1'b1;
      a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
      exp_comb(4, 4'hF, 1'b1, "w_ff1");
      exp_reg(4, 1, 4'hF, 1'b1, 1'b0, "wq_ff1");
      go();
      a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
      exp_comb(4, 4'h8, 1'b0, "w_71");
      exp_reg(4, 1, 4'h8, 1'b0, 1'b1, "wq_71");
      go();
      a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
      exp_comb(4, 4'h0, 1'b1, "w_88");
      exp_reg(4, 1, 4'h0, 1'b1, 1'b1, "wq_88");
      go();
      go();
      go();

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
